// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: runs one DSP48A1-style slice as a multiply-accumulate engine.
// Operand pairs arrive on a valid/ready stream, are issued to slice A/B with
// opmode X=M, Z=P, and the accumulated P is returned on a valid/ready result port.
// Ports:
//   clk, RST_N            clock (rising edge) and async active-low reset
//   start, len            begin a MAC of len pairs (sampled in IDLE only)
//   in_valid/in_ready     operand stream handshake, in_a/in_b 18-bit operands
//   dsp_A/B/opmode/CE/RST slice control, dsp_P slice accumulator readback
//   res_valid/res_ready   result handshake, res_data 48-bit accumulated sum
//   busy                  high whenever the sequencer is not IDLE
module dsp_mac_sequencer #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned OPM_LAT = 1,
  parameter int unsigned P_LAT   = 1
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_CE,
  output logic             dsp_RST,
  input  logic [47:0]      dsp_P,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             busy
);

  localparam int unsigned D_W      = 18;
  localparam int unsigned P_W      = 48;
  localparam int unsigned DRN_LAST = MUL_LAT + P_LAT;
  localparam int unsigned DRN_W    = $clog2(DRN_LAST + 1);
  localparam int unsigned OPM_DLY  = MUL_LAT - OPM_LAT;
  localparam int unsigned OPM_W    = (OPM_DLY < 1) ? 1 : $clog2(OPM_DLY + 1);
  localparam logic [7:0]  OPM_MAC  = 8'h09;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [LEN_W-1:0] count, count_nxt;
  logic [DRN_W-1:0] drn_cnt, drn_nxt;
  logic [OPM_W-1:0] opm_cnt, opm_nxt;

  logic             accept;
  logic             in_ready_nxt, res_valid_nxt, busy_nxt, ce_nxt, rst_nxt;
  logic [D_W-1:0]   a_nxt, b_nxt;
  logic [7:0]       opmode_nxt;
  logic [P_W-1:0]   res_data_nxt;

  // State, counters and every output are registered here.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      len_q      <= '0;
      count      <= '0;
      drn_cnt    <= '0;
      opm_cnt    <= '0;
      in_ready   <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      busy       <= 1'b0;
      dsp_A      <= '0;
      dsp_B      <= '0;
      dsp_opmode <= '0;
      dsp_CE     <= 1'b0;
      dsp_RST    <= 1'b1;
    end else begin
      state      <= state_nxt;
      len_q      <= len_nxt;
      count      <= count_nxt;
      drn_cnt    <= drn_nxt;
      opm_cnt    <= opm_nxt;
      in_ready   <= in_ready_nxt;
      res_valid  <= res_valid_nxt;
      res_data   <= res_data_nxt;
      busy       <= busy_nxt;
      dsp_A      <= a_nxt;
      dsp_B      <= b_nxt;
      dsp_opmode <= opmode_nxt;
      dsp_CE     <= ce_nxt;
      dsp_RST    <= rst_nxt;
    end
  end

  // Next-state logic; outputs are derived from the state being entered.
  always_comb begin
    state_nxt     = state;
    len_nxt       = len_q;
    count_nxt     = count;
    drn_nxt       = drn_cnt;
    opm_nxt       = opm_cnt;
    res_valid_nxt = res_valid;
    res_data_nxt  = res_data;
    a_nxt         = '0;
    b_nxt         = '0;
    accept        = in_valid && in_ready;

    // Opmode delay counter runs once armed by the first issued pair.
    if ((opm_cnt != '0) && (opm_cnt < OPM_W'(OPM_DLY))) begin
      opm_nxt = opm_cnt + OPM_W'(1);
    end

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLR;
          len_nxt   = len;
          count_nxt = '0;
        end
      end
      S_CLR: begin
        drn_nxt   = '0;
        opm_nxt   = '0;
        state_nxt = (len_q == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        if (accept) begin
          a_nxt     = in_a;
          b_nxt     = in_b;
          count_nxt = count + LEN_W'(1);
          if (opm_cnt == '0) opm_nxt = OPM_W'(1);
          if ((count + LEN_W'(1)) == len_q) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Wait for the last product to pass MREG and PREG before sampling P.
        if (drn_cnt == DRN_W'(DRN_LAST)) begin
          res_data_nxt  = dsp_P;
          res_valid_nxt = 1'b1;
          state_nxt     = S_HOLD;
        end else begin
          drn_nxt = drn_cnt + DRN_W'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    in_ready_nxt = (state_nxt == S_FEED) && (count_nxt < len_nxt);
    busy_nxt     = (state_nxt != S_IDLE);
    rst_nxt      = (state_nxt == S_IDLE) || (state_nxt == S_CLR);
    ce_nxt       = (state_nxt == S_CLR) || (state_nxt == S_FEED) || (state_nxt == S_DRAIN);
    opmode_nxt   = (((state_nxt == S_FEED) || (state_nxt == S_DRAIN)) &&
                    (opm_cnt >= OPM_W'(OPM_DLY))) ? OPM_MAC : 8'h00;
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer with a behavioural DSP48A1 slice
// (A1REG, B1REG, MREG, OPMODEREG, PREG) closing the loop on dsp_P.
module tb_dsp_mac_sequencer;

  localparam int unsigned LEN_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_a, in_b;
  logic [17:0]      dsp_A, dsp_B;
  logic [7:0]       dsp_opmode;
  logic             dsp_CE, dsp_RST;
  logic [47:0]      dsp_P;
  logic             res_valid, res_ready;
  logic [47:0]      res_data;
  logic             busy;

  dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .RST_N(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_opmode(dsp_opmode),
    .dsp_CE(dsp_CE), .dsp_RST(dsp_RST), .dsp_P(dsp_P),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural slice: synchronous RST has priority over CE.
  logic signed [17:0] s_a1, s_b1;
  logic signed [35:0] s_m;
  logic [7:0]         s_opm;
  logic [47:0]        s_p, s_x, s_z;

  always_comb begin
    s_x = (s_opm[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0;
    s_z = (s_opm[3:2] == 2'b10) ? s_p : 48'd0;
  end

  always @(posedge clk) begin
    if (dsp_RST) begin
      s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_opm <= '0; s_p <= '0;
    end else if (dsp_CE) begin
      s_a1  <= dsp_A;
      s_b1  <= dsp_B;
      s_m   <= s_a1 * s_b1;
      s_opm <= dsp_opmode;
      s_p   <= s_z + s_x;
    end
  end
  assign dsp_P = s_p;

  int          checks = 0;
  int          failures = 0;
  logic [47:0] sb[$];
  logic [17:0] pa[$], pb[$];
  bit          opm_pending = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: each result handshake consumes the oldest expected sum.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0h required=none", res_data);
      end else begin
        chk("sb_res_data", 64'(res_data), 64'(sb.pop_front()));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    if (opm_pending) begin
      opm_pending = 1'b0;
      chk("opmode_after_first", 64'(dsp_opmode), 64'h09);
    end
  endtask

  // Independent golden sum: sext48 of the low 36 product bits, wrapped to 48.
  function automatic logic [47:0] golden(input int n);
    logic [47:0] acc;
    longint      pr;
    logic [35:0] p36;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      pr  = longint'($signed(pa[i])) * longint'($signed(pb[i]));
      p36 = pr[35:0];
      acc = acc + {{12{p36[35]}}, p36};
    end
    return acc;
  endfunction

  task automatic run_mac(input string nm, input int n, input int gap, input int hold,
                         input logic [47:0] exp);
    int          wd;
    int          lat;
    bit          ready_seen;
    bit          bub_ok;
    bit          stall_ok;
    logic [47:0] d0;
    sb.push_back(exp);
    start = 1'b1;
    len   = LEN_W'(n);
    tick;
    start = 1'b0;
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    bub_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          tick;
          if (dsp_A != '0 || dsp_B != '0) bub_ok = 1'b0;
        end
      end
      in_valid = 1'b1;
      in_a     = pa[i];
      in_b     = pb[i];
      wd = 0;
      while (!in_ready && wd < 20) begin
        tick;
        wd++;
      end
      if (!in_ready) begin
        chk({nm, "_ready_timeout"}, 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
      tick;
      if (i == 0) begin
        chk({nm, "_issue_first"}, {28'd0, dsp_A, dsp_B}, {28'd0, pa[0], pb[0]});
        opm_pending = 1'b1;
      end
    end
    if (gap > 0) chk({nm, "_bubble_zero"}, 64'(bub_ok), 64'd1);
    // Keep offering a pair after the last one; it must not be taken.
    in_valid   = 1'b1;
    in_a       = 18'h00155;
    in_b       = 18'h002AA;
    ready_seen = 1'b0;
    if (n > 0) chk({nm, "_ready_drop"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!res_valid && lat < 40) begin
      tick;
      lat++;
      if (in_ready) ready_seen = 1'b1;
    end
    in_valid = 1'b0;
    chk({nm, "_no_ready_after"}, 64'(ready_seen), 64'd0);
    chk({nm, "_res_valid"}, 64'(res_valid), 64'd1);
    if (n > 0) chk({nm, "_latency"}, 64'(lat), 64'd4);
    d0 = res_data;
    stall_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      start     = (h == hold / 2);
      tick;
      if (!res_valid || res_data !== d0 || dsp_CE) stall_ok = 1'b0;
    end
    if (hold > 0) chk({nm, "_hold_stable"}, 64'(stall_ok), 64'd1);
    res_ready = 1'b1;
    start     = 1'b1;
    tick;
    res_ready = 1'b0;
    start     = 1'b0;
    chk({nm, "_release"}, {62'd0, res_valid, busy}, 64'd0);
  endtask

  typedef struct packed {
    logic [7:0]        n;
    logic [3:0][17:0]  a;
    logic [3:0][17:0]  b;
    logic [3:0]        gap;
    logic [3:0]        hold;
    logic [47:0]       exp;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [17:0] a0, b0, a1, b1, a2, b2, a3, b3,
                              input int gap, input int hold, input logic [47:0] exp);
    vec_t v;
    v.n    = 8'(n);
    v.a    = {a3, a2, a1, a0};
    v.b    = {b3, b2, b1, b0};
    v.gap  = 4'(gap);
    v.hold = 4'(hold);
    v.exp  = exp;
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick;
    chk("reset_ctl", {59'd0, in_ready, res_valid, busy, dsp_CE, dsp_RST}, 64'd1);
    chk("reset_data", {10'd0, |dsp_A, |dsp_B, |dsp_opmode, res_data}, 64'd0);
    rst_n = 1'b1;
    tick;
    chk("idle_busy", 64'(busy), 64'd0);

    //                 n   a0      b0      a1      b1      a2   b2   a3   b3  gap hold exp
    vecs[0] = mk(3, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 0, 0, 0, 0, 48'd68);
    vecs[1] = mk(3, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 0, 0, 2, 0, 48'd68);
    vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 48'd0);
    vecs[3] = mk(2, 18'd5, 18'd6, 18'd7, 18'd8, 0, 0, 0, 0, 0, 10, 48'd86);
    vecs[4] = mk(1, 18'h20000, 18'h3FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 48'h000000020000);
    vecs[5] = mk(4, 18'h3FFFF, 18'h3FFFF, 18'h1FFFF, 18'h1FFFF, 18'h20000, 18'h20000,
                 18'h3FFFE, 18'd5, 1, 0, 48'h0007FFFBFFF8);

    for (int v = 0; v < 6; v++) begin
      pa.delete();
      pb.delete();
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        pa.push_back(vecs[v].a[i]);
        pb.push_back(vecs[v].b[i]);
      end
      run_mac($sformatf("v%0d", v), int'(vecs[v].n), int'(vecs[v].gap),
              int'(vecs[v].hold), vecs[v].exp);
    end

    // Maximum length: 255 pairs of (-3)*7, sum -5355 wrapped to 48 bits.
    pa.delete();
    pb.delete();
    for (int i = 0; i < 255; i++) begin
      pa.push_back(18'h3FFFD);
      pb.push_back(18'd7);
    end
    run_mac("maxlen", 255, 0, 0, 48'hFFFFFFFFEB15);

    // Random operands against the golden function.
    pa.delete();
    pb.delete();
    for (int i = 0; i < 4; i++) begin
      pa.push_back(18'($urandom));
      pb.push_back(18'($urandom));
    end
    run_mac("rand", 4, 1, 2, golden(4));

    // Abort mid-FEED after 2 of 5 pairs: outputs return to reset values at once.
    start = 1'b1;
    len   = LEN_W'(5);
    tick;
    start    = 1'b0;
    in_valid = 1'b1;
    in_a     = 18'd1;
    in_b     = 18'd1;
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", {59'd0, in_ready, res_valid, busy, dsp_CE, dsp_RST}, 64'd1);
    chk("abort_data", {10'd0, |dsp_A, |dsp_B, |dsp_opmode, res_data}, 64'd0);
    in_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    pa.delete();
    pb.delete();
    pa.push_back(18'd9);
    pb.push_back(18'd9);
    run_mac("recover", 1, 0, 0, 48'd81);

    repeat (3) tick;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
